// File: rtl/led_shift_ctrl.sv
// led_shift_ctrl: top-level control for the LED shifter.
//
// Synchronizes and debounces the four pushbuttons. It drives the tick counter's
// enable, limit select and clear signals. On each accepted terminal-count tick it
// advances the LED pattern according to the current mode and direction.
//
// Ports:
//   clk             system clock, all state on rising edge
//   i_reset         asynchronous active-high reset
//   i_sw[0]         run enable (other switches unused)
//   i_btn[3:0]      raw pushbuttons, active-high, asynchronous to clk
//                   [0] next limit select, [1] toggle direction,
//                   [2] next mode, [3] pause/resume
//   i_tick          counter terminal-count pulse
//   o_count_enable  counter enable
//   o_count_sel     counter limit select
//   o_count_clear   one-cycle clear request to the counter
//   o_led           LED pattern
//   o_mode          00 rotate, 01 ping-pong, 10 flash
`timescale 1ns/1ps
module led_shift_ctrl #(
    parameter int unsigned NB_LEDS         = 4,
    parameter int unsigned NB_SEL          = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic [3:0]         i_sw,
    input  logic [3:0]         i_btn,
    input  logic               i_tick,
    output logic               o_count_enable,
    output logic [NB_SEL-1:0]  o_count_sel,
    output logic               o_count_clear,
    output logic [NB_LEDS-1:0] o_led,
    output logic [1:0]         o_mode
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [NB_LEDS-1:0] LED_ONE = NB_LEDS'(1);

    typedef enum logic [1:0] {
        ModeRotate   = 2'b00,
        ModePingpong = 2'b01,
        ModeFlash    = 2'b10,
        ModeRsvd     = 2'b11
    } mode_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Only the run-enable switch is used.
    logic unused_sw;
    assign unused_sw = ^i_sw[3:1];

    // ------------------------------------------------------------------
    // Button synchronizer and debouncer
    // ------------------------------------------------------------------
    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    deb_q, deb_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [3:0]    press;

    always_comb begin
        deb_d = deb_q;
        press = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                    // Only a rising debounced level is an event; release is silent.
                    press[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // ------------------------------------------------------------------
    // Mode / pattern control
    // ------------------------------------------------------------------
    mode_e              mode_q, mode_d;
    logic               dir_q, dir_d;
    logic               paused_q, paused_d;
    logic [NB_LEDS-1:0] led_q, led_d;
    logic [NB_SEL-1:0]  sel_q, sel_d;
    logic               en_q, en_d;
    logic               clear_q, clear_d;
    logic               tick_ok;

    always_comb begin
        mode_d   = mode_q;
        dir_d    = dir_q;
        paused_d = paused_q;
        led_d    = led_q;
        sel_d    = sel_q;
        clear_d  = press[0] | press[2];
        // A tick coinciding with any button event is dropped, not deferred.
        tick_ok  = i_tick & en_q & ~(|press);

        if (press[0]) sel_d = sel_q + 1'b1;
        if (press[1]) dir_d = ~dir_q;
        if (press[3]) paused_d = ~paused_q;

        if (press[2]) begin
            case (mode_q)
                ModeRotate:   mode_d = ModePingpong;
                ModePingpong: mode_d = ModeFlash;
                default:      mode_d = ModeRotate;
            endcase
            led_d = (mode_d == ModeFlash) ? '0 : LED_ONE;
            // Mode change always restarts moving left, overriding a direction toggle.
            dir_d = DIR_LEFT;
        end else if (tick_ok) begin
            case (mode_q)
                ModePingpong: begin
                    if (dir_q == DIR_LEFT) begin
                        if (led_q[NB_LEDS-1]) begin
                            dir_d = DIR_RIGHT;
                            led_d = led_q >> 1;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end else begin
                        if (led_q[0]) begin
                            dir_d = DIR_LEFT;
                            led_d = led_q << 1;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                end
                ModeFlash: led_d = ~led_q;
                default: begin
                    if (dir_q == DIR_LEFT) led_d = {led_q[NB_LEDS-2:0], led_q[NB_LEDS-1]};
                    else                   led_d = {led_q[0], led_q[NB_LEDS-1:1]};
                end
            endcase
        end

        en_d = i_sw[0] & ~paused_d;
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            mode_q   <= ModeRotate;
            dir_q    <= DIR_LEFT;
            paused_q <= 1'b0;
            led_q    <= LED_ONE;
            sel_q    <= '0;
            en_q     <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            paused_q <= paused_d;
            led_q    <= led_d;
            sel_q    <= sel_d;
            en_q     <= en_d;
            clear_q  <= clear_d;
        end
    end

    assign o_count_enable = en_q;
    assign o_count_sel    = sel_q;
    assign o_count_clear  = clear_q;
    assign o_led          = led_q;
    assign o_mode         = mode_q;

endmodule

// File: tb/tb_led_shift_ctrl.sv
`timescale 1ns/1ps
module tb_led_shift_ctrl;

    localparam int N         = 4;
    localparam int DEB       = 4;
    localparam int PRESS_LAT = 2 + DEB;  // edges from clean press to applied event

    logic       clk = 1'b0;
    logic       i_reset;
    logic [3:0] i_sw, i_btn;
    logic       i_tick;
    logic       o_count_enable, o_count_clear;
    logic [1:0] o_count_sel, o_mode;
    logic [3:0] o_led;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    led_shift_ctrl #(
        .NB_LEDS(N),
        .NB_SEL(2),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .i_reset(i_reset),
        .i_sw(i_sw),
        .i_btn(i_btn),
        .i_tick(i_tick),
        .o_count_enable(o_count_enable),
        .o_count_sel(o_count_sel),
        .o_count_clear(o_count_clear),
        .o_led(o_led),
        .o_mode(o_mode)
    );

    // Reference model: LED position as an integer, direction as +1/-1.
    int m_pos, m_dir, m_mode, m_sel;
    bit m_flash_on, m_paused, m_sw, m_en;

    function automatic logic [3:0] m_led();
        if (m_mode == 2) return m_flash_on ? 4'hF : 4'h0;
        return 4'(1 << m_pos);
    endfunction

    task automatic model_reset();
        m_pos = 0; m_dir = 1; m_mode = 0; m_sel = 0;
        m_flash_on = 0; m_paused = 0; m_en = 0;
    endtask

    task automatic model_tick();
        if (m_mode == 0) begin
            m_pos = (m_pos + m_dir + N) % N;
        end else if (m_mode == 1) begin
            if (m_dir == 1 && m_pos == N - 1) m_dir = -1;
            else if (m_dir == -1 && m_pos == 0) m_dir = 1;
            m_pos = m_pos + m_dir;
        end else begin
            m_flash_on = !m_flash_on;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input bit t);
        i_tick = t;
        step();
        i_tick = 1'b0;
        if (t && m_en) model_tick();
        chk("tick_led", 32'(o_led), 32'(m_led()));
        chk("tick_mode", 32'(o_mode), 32'(m_mode));
    endtask

    // Clean press of all buttons in mask; optional tick in the event cycle.
    task automatic press(input logic [3:0] mask, input bit with_tick);
        i_btn = mask;
        repeat (PRESS_LAT - 1) step();
        i_tick = with_tick;
        step();
        i_tick = 1'b0;
        if (mask[0]) m_sel = (m_sel + 1) % 4;
        if (mask[1]) m_dir = -m_dir;
        if (mask[3]) m_paused = !m_paused;
        if (mask[2]) begin
            m_mode = (m_mode + 1) % 3;
            m_pos = 0; m_flash_on = 0; m_dir = 1;
        end
        m_en = m_sw & !m_paused;
        chk("press_sel", 32'(o_count_sel), 32'(m_sel));
        chk("press_mode", 32'(o_mode), 32'(m_mode));
        chk("press_led", 32'(o_led), 32'(m_led()));
        chk("press_en", 32'(o_count_enable), 32'(m_en));
        chk("press_clear_hi", 32'(o_count_clear), 32'(mask[0] | mask[2]));
        step();
        chk("press_clear_lo", 32'(o_count_clear), 32'd0);
        i_btn = 4'h0;
        repeat (PRESS_LAT + 2) step();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_led"}, 32'(o_led), 32'h1);
        chk({tag, "_mode"}, 32'(o_mode), 32'h0);
        chk({tag, "_sel"}, 32'(o_count_sel), 32'h0);
        chk({tag, "_en"}, 32'(o_count_enable), 32'h0);
        chk({tag, "_clear"}, 32'(o_count_clear), 32'h0);
    endtask

    initial begin
        int clears;
        i_reset = 1'b1; i_sw = 4'h0; i_btn = 4'h0; i_tick = 1'b0; m_sw = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst");
        i_reset = 1'b0;
        step();

        // Run enable appears one cycle after the switch.
        i_sw = 4'h1; m_sw = 1;
        step();
        m_en = 1;
        chk("sw_en", 32'(o_count_enable), 32'd1);

        // Rotate left: 0010, 0100, 1000, 0001, 0010, 0100.
        repeat (6) tick(1'b1);
        repeat (20) tick(1'($urandom_range(0, 1)));

        // Bouncy btn[0], then held: exactly one event and one clear pulse.
        clears = 0;
        for (int c = 0; c < 10; c++) begin
            i_btn[0] = ((c / 2) % 2) == 0;
            step();
            clears += int'(o_count_clear);
        end
        i_btn[0] = 1'b1;
        repeat (12) begin
            step();
            clears += int'(o_count_clear);
        end
        m_sel = (m_sel + 1) % 4;
        chk("bounce_clear_pulses", 32'(clears), 32'd1);
        chk("bounce_sel", 32'(o_count_sel), 32'(m_sel));
        i_btn = 4'h0;
        repeat (PRESS_LAT + 2) step();
        repeat (4) press(4'b0001, 1'b0);  // 10, 11, 00, 01

        // Ping-pong walk, bounce at MSB.
        press(4'b0100, 1'b0);
        repeat (5) tick(1'b1);
        repeat (16) tick(1'($urandom_range(0, 1)));

        // Flash.
        press(4'b0100, 1'b0);
        repeat (2) tick(1'b1);
        repeat (8) tick(1'($urandom_range(0, 1)));

        // Back to rotate, then pause / resume.
        press(4'b0100, 1'b0);
        press(4'b1000, 1'b0);
        repeat (3) tick(1'b1);
        press(4'b1000, 1'b0);
        repeat (2) tick(1'b1);  // 0010, 0100

        // Direction toggle coincident with tick: tick dropped, then moves right.
        press(4'b0010, 1'b1);
        tick(1'b1);
        // Direction toggle with mode change: mode change forces left.
        press(4'b0110, 1'b0);
        tick(1'b1);

        // Into flash with select 10, then asynchronous reset between edges.
        press(4'b0100, 1'b0);
        press(4'b0001, 1'b0);
        tick(1'b1);
        chk("pre_rst_sel", 32'(o_count_sel), 32'h2);
        @(posedge clk);
        #2;
        i_reset = 1'b1;
        #1;
        chk_reset_state("async_rst");
        step();
        i_reset = 1'b0;
        model_reset();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
